// File: rtl/mask_merge_buffer.sv
// Byte-masked write-combining buffer: merges word writes into one held line and
// hands the line downstream on fill, address change or explicit flush.
module mask_merge_buffer #(
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [8*WORD_BYTES-1:0]      wr_data,
   input  logic [WORD_BYTES-1:0]        wr_mask,
   input  logic                         flush_req,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_W-1:0]            out_addr,
   output logic [8*WORD_BYTES*LINE_WORDS-1:0] out_data,
   output logic [WORD_BYTES*LINE_WORDS-1:0]   out_bmask,
   output logic [8*WORD_BYTES*LINE_WORDS-1:0] out_mask,
   output logic                         empty
);

   localparam int unsigned LB     = WORD_BYTES * LINE_WORDS;
   localparam int unsigned OFS    = $clog2(LB);
   localparam int unsigned WB_W   = $clog2(WORD_BYTES);
   localparam int unsigned WIDX_W = $clog2(LINE_WORDS);
   localparam int unsigned LW     = 8 * LB;

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_FILLING = 2'd1,
      S_FLUSH   = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [ADDR_W-1:0]   tag_q;
   logic [LW-1:0]       line_q;
   logic [LB-1:0]       bmask_q;

   logic [ADDR_W-1:0]   wr_tag;
   logic [WIDX_W-1:0]   widx;
   logic                tag_match;
   logic                accept;
   logic                merge_en;
   logic                clear_en;
   logic                line_full;
   logic [LW-1:0]       merged_line;
   logic [LB-1:0]       merged_bm;
   logic                unused_addr_bits;

   // Address decomposition: the byte-within-word bits only select nothing.
   assign wr_tag           = {wr_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
   assign widx             = wr_addr[WB_W +: WIDX_W];
   assign tag_match        = (wr_tag == tag_q);
   assign unused_addr_bits = ^(wr_addr & ADDR_W'(WORD_BYTES - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM outputs and handshake decode
   always_comb begin
      wr_ready  = 1'b0;
      out_valid = 1'b0;
      empty     = 1'b0;
      unique case (state)
         S_EMPTY: begin
            wr_ready = 1'b1;
            empty    = 1'b1;
         end
         S_FILLING: begin
            wr_ready = tag_match & ~flush_req;
         end
         S_FLUSH: begin
            out_valid = 1'b1;
         end
         default: begin
            wr_ready = 1'b0;
         end
      endcase
   end

   assign accept   = wr_valid & wr_ready;
   assign merge_en = accept & (|wr_mask);
   assign clear_en = out_valid & out_ready;

   // Byte-lane merge of the incoming word into the held line
   always_comb begin
      merged_line = line_q;
      merged_bm   = bmask_q;
      for (int unsigned w = 0; w < LINE_WORDS; w++) begin
         for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if ((widx == WIDX_W'(w)) && wr_mask[i]) begin
               merged_line[(w*WORD_BYTES + i)*8 +: 8] = wr_data[i*8 +: 8];
               merged_bm[w*WORD_BYTES + i]            = 1'b1;
            end
         end
      end
   end

   assign line_full = &merged_bm;

   // Next-state logic; flush_req outranks a concurrent write
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_EMPTY: begin
            if (merge_en) begin
               state_nxt = line_full ? S_FLUSH : S_FILLING;
            end
         end
         S_FILLING: begin
            if (flush_req) begin
               state_nxt = S_FLUSH;
            end else if (wr_valid && !tag_match) begin
               state_nxt = S_FLUSH;
            end else if (merge_en && line_full) begin
               state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (out_ready) begin
               state_nxt = S_EMPTY;
            end
         end
         default: begin
            state_nxt = S_EMPTY;
         end
      endcase
   end

   // Line storage: cleared on transfer, updated on every non-empty accepted write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q   <= '0;
         line_q  <= '0;
         bmask_q <= '0;
      end else if (clear_en) begin
         line_q  <= '0;
         bmask_q <= '0;
      end else if (merge_en) begin
         tag_q   <= wr_tag;
         line_q  <= merged_line;
         bmask_q <= merged_bm;
      end
   end

   assign out_addr  = tag_q;
   assign out_data  = line_q;
   assign out_bmask = bmask_q;

   // Bit-level expansion of the byte mask
   always_comb begin
      out_mask = '0;
      for (int unsigned k = 0; k < LB; k++) begin
         out_mask[k*8 +: 8] = {8{bmask_q[k]}};
      end
   end

endmodule

// File: tb/tb_mask_merge_buffer.sv
// Directed table-driven bench for mask_merge_buffer (default parameters).
module tb_mask_merge_buffer;

   logic          clk;
   logic          rst_n;
   logic          wr_valid;
   logic          wr_ready;
   logic [31:0]   wr_addr;
   logic [31:0]   wr_data;
   logic [3:0]    wr_mask;
   logic          flush_req;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_addr;
   logic [255:0]  out_data;
   logic [31:0]   out_bmask;
   logic [255:0]  out_mask;
   logic          empty;

   int n_cmp = 0;
   int n_err = 0;

   mask_merge_buffer #(.WORD_BYTES(4), .LINE_WORDS(8), .ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_mask   (wr_mask),
      .flush_req (flush_req),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_bmask (out_bmask),
      .out_mask  (out_mask),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic [31:0]   a;
      logic [31:0]   d;
      logic [3:0]    m;
      logic          f;
      logic          o;
      logic          exp_rdy;
      logic          exp_ov;
      logic          exp_empty;
      logic [31:0]   exp_bm;
      logic          chk_addr;
      logic [31:0]   exp_addr;
      logic [255:0]  exp_data;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic v, logic [31:0] a, logic [31:0] d, logic [3:0] m,
                               logic f, logic o, logic er, logic eov, logic eem,
                               logic [31:0] ebm, logic ca, logic [31:0] ea, logic [255:0] ed);
      vec_t r;
      r.v = v; r.a = a; r.d = d; r.m = m; r.f = f; r.o = o;
      r.exp_rdy = er; r.exp_ov = eov; r.exp_empty = eem; r.exp_bm = ebm;
      r.chk_addr = ca; r.exp_addr = ea; r.exp_data = ed;
      return r;
   endfunction

   function automatic logic [255:0] expand(logic [31:0] bm);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < 32; k++) r[k*8 +: 8] = {8{bm[k]}};
      return r;
   endfunction

   task automatic chk(string name, int idx, logic [255:0] act, logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(logic v, logic [31:0] a, logic [31:0] d, logic [3:0] m, logic f, logic o);
      wr_valid = v; wr_addr = a; wr_data = d; wr_mask = m; flush_req = f; out_ready = o;
   endtask

   initial begin
      logic [255:0] ed;
      logic [31:0]  bm;
      logic [31:0]  dj;

      // Merge and explicit flush; mask-0 write and flush while empty are no-ops
      vq.push_back(mk(0, 32'h0,   32'h0,        4'h0,    0, 0, 1, 0, 1, 32'h0, 1, 32'h0,   256'h0));
      vq.push_back(mk(0, 32'h0,   32'h0,        4'h0,    1, 0, 1, 0, 1, 32'h0, 1, 32'h0,   256'h0));
      vq.push_back(mk(1, 32'h400, 32'hDEADBEEF, 4'h0,    0, 0, 1, 0, 1, 32'h0, 1, 32'h0,   256'h0));
      vq.push_back(mk(1, 32'h100, 32'hAABBCCDD, 4'b0101, 0, 0, 1, 0, 0, 32'h5, 1, 32'h100, 256'h00BB00DD));
      vq.push_back(mk(1, 32'h100, 32'h11223344, 4'b1010, 0, 0, 1, 0, 0, 32'hF, 1, 32'h100, 256'h11BB33DD));
      vq.push_back(mk(1, 32'h104, 32'hFFFFFFFF, 4'hF,    1, 0, 0, 1, 0, 32'hF, 1, 32'h100, 256'h11BB33DD));
      vq.push_back(mk(0, 32'h0,   32'h0,        4'h0,    0, 0, 0, 1, 0, 32'hF, 1, 32'h100, 256'h11BB33DD));
      vq.push_back(mk(0, 32'h0,   32'h0,        4'h0,    0, 1, 0, 0, 1, 32'h0, 0, 32'h0,   256'h0));
      // Eight full-word writes: auto-flush after the last one
      ed = '0;
      for (int j = 0; j < 8; j++) begin
         dj = 32'h01010101 * (j + 1);
         ed[j*32 +: 32] = dj;
         bm = (j == 7) ? 32'hFFFFFFFF : ((32'h1 << (4*(j+1))) - 32'h1);
         vq.push_back(mk(1, 32'h200 + 32'(4*j), dj, 4'hF, 0, 0, 1, (j == 7), 0, bm, 1, 32'h200, ed));
      end
      vq.push_back(mk(0, 32'h0,   32'h0,  4'h0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 32'h200, ed));
      vq.push_back(mk(0, 32'h0,   32'h0,  4'h0, 0, 1, 0, 0, 1, 32'h0, 0, 32'h0,   256'h0));
      // Tag mismatch evicts the held line, then the new write lands in EMPTY
      vq.push_back(mk(1, 32'h300, 32'hAB, 4'h1, 0, 0, 1, 0, 0, 32'h1, 1, 32'h300, 256'hAB));
      vq.push_back(mk(1, 32'h340, 32'hCD, 4'h1, 0, 0, 0, 1, 0, 32'h1, 1, 32'h300, 256'hAB));
      vq.push_back(mk(1, 32'h340, 32'hCD, 4'h1, 0, 1, 0, 0, 1, 32'h0, 0, 32'h0,   256'h0));
      vq.push_back(mk(1, 32'h340, 32'hCD, 4'h1, 0, 1, 1, 0, 0, 32'h1, 1, 32'h340, 256'hCD));
      // Backpressure: line stays stable while out_ready is low
      vq.push_back(mk(0, 32'h0,   32'h0,  4'h0, 1, 0, 0, 1, 0, 32'h1, 1, 32'h340, 256'hCD));
      for (int j = 0; j < 5; j++)
         vq.push_back(mk(1, 32'h340, 32'hCD, 4'h1, 0, 0, 0, 1, 0, 32'h1, 1, 32'h340, 256'hCD));
      vq.push_back(mk(0, 32'h0,   32'h0,  4'h0, 0, 1, 0, 0, 1, 32'h0, 0, 32'h0,   256'h0));

      rst_n = 1'b0;
      drive(0, 32'h0, 32'h0, 4'h0, 0, 0);
      #1;
      chk("rst_out_valid", -1, 256'(out_valid), 256'h0);
      chk("rst_empty",     -1, 256'(empty),     256'h1);
      chk("rst_out_bmask", -1, 256'(out_bmask), 256'h0);
      chk("rst_out_mask",  -1, out_mask,        256'h0);
      chk("rst_out_data",  -1, out_data,        256'h0);
      chk("rst_out_addr",  -1, 256'(out_addr),  256'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         drive(vq[i].v, vq[i].a, vq[i].d, vq[i].m, vq[i].f, vq[i].o);
         #1;
         chk("wr_ready", i, 256'(wr_ready), 256'(vq[i].exp_rdy));
         @(posedge clk);
         #1;
         chk("out_valid", i, 256'(out_valid), 256'(vq[i].exp_ov));
         chk("empty",     i, 256'(empty),     256'(vq[i].exp_empty));
         chk("out_bmask", i, 256'(out_bmask), 256'(vq[i].exp_bm));
         chk("out_mask",  i, out_mask,        expand(vq[i].exp_bm));
         chk("out_data",  i, out_data,        vq[i].exp_data);
         if (vq[i].chk_addr)
            chk("out_addr", i, 256'(out_addr), 256'(vq[i].exp_addr));
      end

      // Reset asserted during FLUSH clears outputs without a clock edge
      drive(1, 32'h500, 32'h12345678, 4'hF, 0, 0);
      @(posedge clk);
      #1;
      drive(0, 32'h0, 32'h0, 4'h0, 1, 0);
      @(posedge clk);
      #1;
      chk("rf_out_valid", 100, 256'(out_valid), 256'h1);
      chk("rf_out_addr",  100, 256'(out_addr),  256'h500);
      drive(0, 32'h0, 32'h0, 4'h0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rf_rst_valid", 101, 256'(out_valid), 256'h0);
      chk("rf_rst_empty", 101, 256'(empty),     256'h1);
      chk("rf_rst_bmask", 101, 256'(out_bmask), 256'h0);
      chk("rf_rst_data",  101, out_data,        256'h0);
      chk("rf_rst_mask",  101, out_mask,        256'h0);
      chk("rf_rst_addr",  101, 256'(out_addr),  256'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 32'h0, 32'h0, 4'h0, 1, 1);
      #1;
      chk("rf_wr_ready", 102, 256'(wr_ready), 256'h1);
      for (int j = 0; j < 3; j++) begin
         @(posedge clk);
         #1;
         chk("rf_post_valid", 103 + j, 256'(out_valid), 256'h0);
         chk("rf_post_empty", 103 + j, 256'(empty),     256'h1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
